hmac_sha256_var: RTL and testbench

HMAC_SHA256_VAR -- requirements
Module: hmac_sha256_var

---
 rtl/hmac_sha256_var.sv | 265 ++++++++++++++++++++++++++
 tb/tb_hmac_sha256_var.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hmac_sha256_var.sv
// HMAC-SHA256 over a fixed-length key and message, sequenced through one iterative
// SHA-256 compression core. Define HMAC_KEYCACHE_EN to cache the key midstates.

module sha256 (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         enable,
    input  logic [511:0] data,
    input  logic [255:0] current_hash,
    output logic [255:0] hash,
    output logic         hash_done
);
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         run_reg;
    logic [5:0]   round_reg;
    logic [31:0]  v_reg [8];
    logic [31:0]  v_next [8];
    logic [31:0]  w_reg [16];
    logic [31:0]  w_new;
    logic [255:0] base_reg;
    logic [255:0] sum;
    logic         load;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // The done cycle is skipped so a still-high enable cannot re-run the old block.
    assign load = enable && !run_reg && !hash_done;

    always_comb begin
        logic [31:0] t1;
        logic [31:0] t2;
        t1 = v_reg[7] + (rotr(v_reg[4], 6) ^ rotr(v_reg[4], 11) ^ rotr(v_reg[4], 25))
           + ((v_reg[4] & v_reg[5]) ^ (~v_reg[4] & v_reg[6])) + K[round_reg] + w_reg[0];
        t2 = (rotr(v_reg[0], 2) ^ rotr(v_reg[0], 13) ^ rotr(v_reg[0], 22))
           + ((v_reg[0] & v_reg[1]) ^ (v_reg[0] & v_reg[2]) ^ (v_reg[1] & v_reg[2]));
        v_next[0] = t1 + t2;
        v_next[1] = v_reg[0];
        v_next[2] = v_reg[1];
        v_next[3] = v_reg[2];
        v_next[4] = v_reg[3] + t1;
        v_next[5] = v_reg[4];
        v_next[6] = v_reg[5];
        v_next[7] = v_reg[6];
        w_new = (rotr(w_reg[14], 17) ^ rotr(w_reg[14], 19) ^ (w_reg[14] >> 10)) + w_reg[9]
              + (rotr(w_reg[1], 7) ^ rotr(w_reg[1], 18) ^ (w_reg[1] >> 3)) + w_reg[0];
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_sum
            assign sum[255-32*gi -: 32] = base_reg[255-32*gi -: 32] + v_next[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            run_reg   <= 1'b0;
            round_reg <= '0;
            hash_done <= 1'b0;
        end else begin
            hash_done <= 1'b0;
            if (load) begin
                run_reg   <= 1'b1;
                round_reg <= '0;
            end else if (run_reg) begin
                round_reg <= round_reg + 6'd1;
                if (round_reg == 6'd63) begin
                    run_reg   <= 1'b0;
                    hash_done <= 1'b1;
                end
            end
        end
    end

    // Message schedule kept as a 16-word sliding window; w_reg[0] is W[t].
    always_ff @(posedge clk) begin
        if (load) begin
            base_reg <= current_hash;
            for (int i = 0; i < 8; i++) v_reg[i] <= current_hash[255-32*i -: 32];
            for (int i = 0; i < 16; i++) w_reg[i] <= data[511-32*i -: 32];
        end else if (run_reg) begin
            for (int i = 0; i < 8; i++) v_reg[i] <= v_next[i];
            for (int i = 0; i < 15; i++) w_reg[i] <= w_reg[i+1];
            w_reg[15] <= w_new;
            if (round_reg == 6'd63) hash <= sum;
        end
    end
endmodule

module hmac_sha256_var #(
    parameter int MSG_BYTES = 84,
    parameter int KEY_BYTES = 32
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   start,
    input  logic [KEY_BYTES*8-1:0] key,
    input  logic [MSG_BYTES*8-1:0] msg,
    input  logic                   key_reuse,
    output logic                   busy,
    output logic [255:0]           hash,
    output logic                   hash_valid
);
    localparam int NBLK = (MSG_BYTES + 9 + 63) / 64;
    localparam int SW   = NBLK * 512;
    localparam logic [63:0]  ILEN     = 64'((64 + MSG_BYTES) * 8);
    localparam logic [2:0]   LAST_BLK = 3'(NBLK - 1);
    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    generate
        if (KEY_BYTES < 1 || KEY_BYTES > 64) begin : g_bad_key
            $error("hmac_sha256_var: KEY_BYTES must be 1..64");
        end
        if (MSG_BYTES < 1 || MSG_BYTES > 247) begin : g_bad_msg
            $error("hmac_sha256_var: MSG_BYTES must be 1..247");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, IKEY, IMSG, OKEY, OFIN, DONE} state_t;
    state_t state_reg, state_next;

    logic [2:0]   blk_reg;
    logic [255:0] inner_reg;
    logic         core_en, core_done;
    logic [511:0] core_data;
    logic [255:0] core_cv, core_hash;
    logic [511:0] key_pad;
    logic [SW-1:0] inner_stream;
    logic [511:0] inner_blk [8];
    logic         fast_start;
    logic         cached;

    assign key_pad      = 512'(key) << ((64 - KEY_BYTES) * 8);
    assign inner_stream = (SW'({msg, 8'h80}) << (SW - MSG_BYTES * 8 - 8)) | SW'(ILEN);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_blk
            if (gi < NBLK) begin : g_used
                assign inner_blk[gi] = inner_stream[SW-1-512*gi -: 512];
            end else begin : g_pad
                assign inner_blk[gi] = '0;
            end
        end
    endgenerate

`ifdef HMAC_KEYCACHE_EN
    logic [255:0] cache_i_reg, cache_o_reg;
    logic         cache_valid_reg, hit_reg;

    assign fast_start = key_reuse && cache_valid_reg;
    assign cached     = hit_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cache_valid_reg <= 1'b0;
            hit_reg         <= 1'b0;
        end else begin
            if (state_reg == IDLE && start) hit_reg <= fast_start;
            if (state_reg == OKEY && core_done) cache_valid_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state_reg == IKEY && core_done) cache_i_reg <= core_hash;
        if (state_reg == OKEY && core_done) cache_o_reg <= core_hash;
    end
`else
    logic unused_key_reuse;
    assign unused_key_reuse = key_reuse;
    assign fast_start       = 1'b0;
    assign cached           = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = fast_start ? IMSG : IKEY;
            IKEY: if (core_done) state_next = IMSG;
            IMSG: if (core_done && blk_reg == LAST_BLK) state_next = cached ? OFIN : OKEY;
            OKEY: if (core_done) state_next = OFIN;
            OFIN: if (core_done) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        core_en    = (state_reg == IKEY) || (state_reg == IMSG) ||
                     (state_reg == OKEY) || (state_reg == OFIN);
        busy       = core_en;
        hash_valid = (state_reg == DONE);
    end

    // Key blocks start from the IV; message/final blocks chain from the previous
    // compression, or from the cached key midstate when the key stage was skipped.
    always_comb begin
        core_data = '0;
        core_cv   = IV;
        case (state_reg)
            IKEY: core_data = key_pad ^ {64{8'h36}};
            IMSG: begin
                core_data = inner_blk[blk_reg];
                core_cv   = core_hash;
`ifdef HMAC_KEYCACHE_EN
                if (cached && blk_reg == 3'd0) core_cv = cache_i_reg;
`endif
            end
            OKEY: core_data = key_pad ^ {64{8'h5c}};
            OFIN: begin
                core_data = {inner_reg, 8'h80, 184'd0, 64'd768};
                core_cv   = core_hash;
`ifdef HMAC_KEYCACHE_EN
                if (cached) core_cv = cache_o_reg;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            blk_reg   <= '0;
            inner_reg <= '0;
            hash      <= '0;
        end else begin
            if (state_next == IMSG && state_reg != IMSG)
                blk_reg <= '0;
            else if (state_reg == IMSG && core_done)
                blk_reg <= blk_reg + 3'd1;
            if (state_reg == IMSG && core_done && blk_reg == LAST_BLK)
                inner_reg <= core_hash;
            if (state_reg == OFIN && core_done)
                hash <= core_hash;
        end
    end

    sha256 u_core (
        .clk          (clk),
        .n_rst        (n_rst),
        .enable       (core_en),
        .data         (core_data),
        .current_hash (core_cv),
        .hash         (core_hash),
        .hash_done    (core_done)
    );
endmodule

// File: tb/tb_hmac_sha256_var.sv
// Self-checking bench for hmac_sha256_var: known-answer vectors, random requests
// against a byte-queue HMAC model, block-boundary, start filtering, reset, key cache.

module tb_hmac_sha256_var;
    typedef byte unsigned bq_t [$];

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] JEFE_HMAC = 256'h5bdcc146bf60754e6a042426089575c75a003f089d2739839dec58b964ec3843;
    localparam logic [255:0] FOX_HMAC  = 256'hf7bc83f430538424b13298e6aa6fb143ef4d59a14946175997479dbc2d1a3cd8;
    // 84-byte message: ceil(93/64) = 2 inner blocks, plus ipad, opad and final block.
    localparam int COMP_D = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic n_rst;

    logic         start_d, reuse_d, busy_d, valid_d;
    logic [255:0] key_d, hash_d;
    logic [671:0] msg_d;

    logic         start_v, reuse_v;
    logic         busy_j, valid_j, busy_q, valid_q, busy_a, valid_a, busy_b, valid_b;
    logic [31:0]  key_j;
    logic [223:0] msg_j;
    logic [23:0]  key_q;
    logic [343:0] msg_q;
    logic [127:0] key_a, key_b;
    logic [439:0] msg_a;
    logic [447:0] msg_b;
    logic [255:0] hash_j, hash_q, hash_a, hash_b;

    int checks = 0;
    int passes = 0;
    int ccnt_d = 0, vcnt_d = 0, ccnt_j = 0, vcnt_j = 0, ccnt_a = 0, ccnt_b = 0;

    hmac_sha256_var u_d (
        .clk(clk), .n_rst(n_rst), .start(start_d), .key(key_d), .msg(msg_d),
        .key_reuse(reuse_d), .busy(busy_d), .hash(hash_d), .hash_valid(valid_d));
    hmac_sha256_var #(.MSG_BYTES(28), .KEY_BYTES(4)) u_j (
        .clk(clk), .n_rst(n_rst), .start(start_v), .key(key_j), .msg(msg_j),
        .key_reuse(reuse_v), .busy(busy_j), .hash(hash_j), .hash_valid(valid_j));
    hmac_sha256_var #(.MSG_BYTES(43), .KEY_BYTES(3)) u_q (
        .clk(clk), .n_rst(n_rst), .start(start_v), .key(key_q), .msg(msg_q),
        .key_reuse(reuse_v), .busy(busy_q), .hash(hash_q), .hash_valid(valid_q));
    hmac_sha256_var #(.MSG_BYTES(55), .KEY_BYTES(16)) u_a (
        .clk(clk), .n_rst(n_rst), .start(start_v), .key(key_a), .msg(msg_a),
        .key_reuse(reuse_v), .busy(busy_a), .hash(hash_a), .hash_valid(valid_a));
    hmac_sha256_var #(.MSG_BYTES(56), .KEY_BYTES(16)) u_b (
        .clk(clk), .n_rst(n_rst), .start(start_v), .key(key_b), .msg(msg_b),
        .key_reuse(reuse_v), .busy(busy_b), .hash(hash_b), .hash_valid(valid_b));

    always @(negedge clk) begin
        if (u_d.u_core.hash_done === 1'b1) ccnt_d++;
        if (u_j.u_core.hash_done === 1'b1) ccnt_j++;
        if (u_a.u_core.hash_done === 1'b1) ccnt_a++;
        if (u_b.u_core.hash_done === 1'b1) ccnt_b++;
        if (valid_d === 1'b1) vcnt_d++;
        if (valid_j === 1'b1) vcnt_j++;
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha256_ref(input bq_t m);
        bq_t p;
        logic [31:0] h [8];
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        longint unsigned bits;
        p = m;
        bits = 64'(m.size()) * 8;
        h = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
              32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
        for (int blk = 0; blk < p.size() / 64; blk++) begin
            for (int t = 0; t < 16; t++)
                w[t] = {p[blk*64+4*t], p[blk*64+4*t+1], p[blk*64+4*t+2], p[blk*64+4*t+3]};
            for (int t = 16; t < 64; t++)
                w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                     + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
            a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
            for (int t = 0; t < 64; t++) begin
                t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
                t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
                hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
            end
            h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
        end
        return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    endfunction

    function automatic logic [255:0] hmac_ref(input bq_t k, input bq_t m);
        bq_t ip, op;
        logic [255:0] d;
        byte unsigned kb;
        for (int i = 0; i < 64; i++) begin
            kb = (i < k.size()) ? k[i] : 8'h00;
            ip.push_back(kb ^ 8'h36);
            op.push_back(kb ^ 8'h5c);
        end
        foreach (m[i]) ip.push_back(m[i]);
        d = sha256_ref(ip);
        for (int i = 0; i < 32; i++) op.push_back(d[255-8*i -: 8]);
        return sha256_ref(op);
    endfunction

    function automatic bq_t bytes_of(input logic [2047:0] v, input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(v[(n-1-i)*8 +: 8]);
        return q;
    endfunction

    function automatic logic [255:0] expect_d();
        return hmac_ref(bytes_of(2048'(key_d), 32), bytes_of(2048'(msg_d), 84));
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic rand_key_d();
        for (int i = 0; i < 32; i++) key_d[8*i +: 8] = 8'($urandom());
    endtask

    task automatic rand_msg_d();
        for (int i = 0; i < 84; i++) msg_d[8*i +: 8] = 8'($urandom());
    endtask

    task automatic run_d(input logic reuse);
        int cyc;
        @(negedge clk);
        reuse_d = reuse;
        start_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0;
        cyc = 0;
        while (valid_d !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 2000) begin
            checks++;
            $display("FAIL run_d_timeout: hash_valid=%b after %0d cycles, required 1", valid_d, cyc);
        end
        @(negedge clk);
    endtask

    task automatic run_vec();
        bit sj, sq, sa, sb;
        int cyc;
        sj = 0; sq = 0; sa = 0; sb = 0;
        @(negedge clk);
        start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        cyc = 0;
        while (!(sj && sq && sa && sb) && cyc < 3000) begin
            if (valid_j === 1'b1) sj = 1;
            if (valid_q === 1'b1) sq = 1;
            if (valid_a === 1'b1) sa = 1;
            if (valid_b === 1'b1) sb = 1;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 3000) begin
            checks++;
            $display("FAIL run_vec_timeout: done j%0d q%0d a%0d b%0d, required all 1", sj, sq, sa, sb);
        end
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_rst = 1'b0; start_d = 1'b0; reuse_d = 1'b0; start_v = 1'b0; reuse_v = 1'b0;
        key_d = '0; msg_d = '0; key_j = "Jefe"; msg_j = "what do ya want for nothing?";
        key_q = "key"; msg_q = "The quick brown fox jumps over the lazy dog";
        key_a = '0; key_b = '0; msg_a = '0; msg_b = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy_d !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy_d); else passes++;
        checks++; if (valid_d !== 1'b0) $display("FAIL reset_valid: got %b, required 0", valid_d); else passes++;
        checks++; if (hash_d !== 256'd0) $display("FAIL reset_hash: got %h, required 0", hash_d); else passes++;
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        $display("reset: busy=%b valid=%b hash=%h", busy_d, valid_d, hash_d);
    endtask

    task automatic test_rfc();
        int c0, v0;
        c0 = ccnt_j; v0 = vcnt_j;
        run_vec();
        $display("rfc: jefe=%h fox=%h", hash_j, hash_q);
        checks++; if (hash_j !== JEFE_HMAC) $display("FAIL rfc_jefe: got %h, required %h", hash_j, JEFE_HMAC); else passes++;
        checks++; if (hash_q !== FOX_HMAC) $display("FAIL rfc_fox: got %h, required %h", hash_q, FOX_HMAC); else passes++;
        checks++; if (vcnt_j - v0 !== 1) $display("FAIL rfc_pulses: got %0d, required 1", vcnt_j - v0); else passes++;
        checks++; if (ccnt_j - c0 !== 4) $display("FAIL rfc_comps: got %0d, required 4", ccnt_j - c0); else passes++;
    endtask

    task automatic test_block_boundary();
        int ca, cb;
        logic [255:0] ea, eb;
        for (int it = 0; it < 2; it++) begin
            for (int i = 0; i < 16; i++) begin
                key_a[8*i +: 8] = 8'($urandom());
                key_b[8*i +: 8] = 8'($urandom());
            end
            for (int i = 0; i < 55; i++) msg_a[8*i +: 8] = 8'($urandom());
            for (int i = 0; i < 56; i++) msg_b[8*i +: 8] = 8'($urandom());
            ea = hmac_ref(bytes_of(2048'(key_a), 16), bytes_of(2048'(msg_a), 55));
            eb = hmac_ref(bytes_of(2048'(key_b), 16), bytes_of(2048'(msg_b), 56));
            ca = ccnt_a; cb = ccnt_b;
            run_vec();
            $display("boundary[%0d]: m55=%h m56=%h comps %0d/%0d", it, hash_a, hash_b, ccnt_a - ca, ccnt_b - cb);
            checks++; if (hash_a !== ea) $display("FAIL b55_hash: got %h, required %h", hash_a, ea); else passes++;
            checks++; if (hash_b !== eb) $display("FAIL b56_hash: got %h, required %h", hash_b, eb); else passes++;
            checks++; if (ccnt_a - ca !== 4) $display("FAIL b55_comps: got %0d, required 4", ccnt_a - ca); else passes++;
            checks++; if (ccnt_b - cb !== 5) $display("FAIL b56_comps: got %0d, required 5", ccnt_b - cb); else passes++;
        end
    endtask

    task automatic test_random();
        int c0;
        logic [255:0] e;
        for (int it = 0; it < 4; it++) begin
            rand_key_d();
            rand_msg_d();
            e = expect_d();
            c0 = ccnt_d;
            run_d(1'b0);
            $display("random[%0d]: hash=%h comps=%0d", it, hash_d, ccnt_d - c0);
            checks++; if (hash_d !== e) $display("FAIL rand_hash: got %h, required %h", hash_d, e); else passes++;
            checks++; if (ccnt_d - c0 !== COMP_D) $display("FAIL rand_comps: got %0d, required %0d", ccnt_d - c0, COMP_D); else passes++;
        end
    endtask

    task automatic test_start_ignored();
        int c0, v0, cyc;
        logic [255:0] e;
        rand_key_d();
        rand_msg_d();
        e = expect_d();
        c0 = ccnt_d; v0 = vcnt_d;
        @(negedge clk); start_d = 1'b1;
        @(negedge clk); start_d = 1'b0;
        repeat (20) @(negedge clk);
        start_d = 1'b1;
        @(negedge clk); start_d = 1'b0;
        cyc = 0;
        while (valid_d !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        start_d = 1'b1;
        @(negedge clk); start_d = 1'b0;
        repeat (600) @(negedge clk);
        $display("start_ignored: pulses=%0d hash=%h busy=%b", vcnt_d - v0, hash_d, busy_d);
        checks++; if (vcnt_d - v0 !== 1) $display("FAIL extra_start_pulses: got %0d, required 1", vcnt_d - v0); else passes++;
        checks++; if (hash_d !== e) $display("FAIL extra_start_hash: got %h, required %h", hash_d, e); else passes++;
        checks++; if (busy_d !== 1'b0) $display("FAIL extra_start_busy: got %b, required 0", busy_d); else passes++;
        checks++; if (ccnt_d - c0 !== COMP_D) $display("FAIL extra_start_comps: got %0d, required %0d", ccnt_d - c0, COMP_D); else passes++;
    endtask

    task automatic test_reset_midop();
        int c0, v0, cyc;
        logic [255:0] prev, e;
        prev = expect_d();
        rand_msg_d();
        e = expect_d();
        c0 = ccnt_d;
        @(negedge clk); start_d = 1'b1;
        @(negedge clk); start_d = 1'b0;
        cyc = 0;
        while (ccnt_d - c0 < 1 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        repeat (10) @(negedge clk);
        checks++; if (hash_d !== prev) $display("FAIL midop_hold: got %h, required %h", hash_d, prev); else passes++;
        n_rst = 1'b0;
        #1;
        checks++; if (busy_d !== 1'b0) $display("FAIL midop_busy: got %b, required 0", busy_d); else passes++;
        checks++; if (hash_d !== 256'd0) $display("FAIL midop_hash: got %h, required 0", hash_d); else passes++;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        v0 = vcnt_d;
        repeat (600) @(negedge clk);
        checks++; if (vcnt_d - v0 !== 0) $display("FAIL midop_pulse: got %0d, required 0", vcnt_d - v0); else passes++;
        run_d(1'b0);
        $display("reset_midop: restart hash=%h", hash_d);
        checks++; if (hash_d !== e) $display("FAIL midop_restart: got %h, required %h", hash_d, e); else passes++;
    endtask

    task automatic test_keycache();
        int c0;
        logic [255:0] e;
`ifdef HMAC_KEYCACHE_EN
        @(negedge clk); n_rst = 1'b0;
        @(negedge clk); n_rst = 1'b1;
        rand_key_d();
        for (int it = 0; it < 3; it++) begin
            rand_msg_d();
            e = expect_d();
            c0 = ccnt_d;
            run_d(1'b1);
            $display("keycache[%0d]: hash=%h comps=%0d", it, hash_d, ccnt_d - c0);
            checks++; if (hash_d !== e) $display("FAIL cache_hash: got %h, required %h", hash_d, e); else passes++;
            // First request after reset cannot hit; later ones skip both key blocks.
            checks++;
            if (ccnt_d - c0 !== ((it == 0) ? COMP_D : COMP_D - 2))
                $display("FAIL cache_comps: got %0d, required %0d", ccnt_d - c0, (it == 0) ? COMP_D : COMP_D - 2);
            else passes++;
        end
`else
        rand_key_d();
        for (int it = 0; it < 2; it++) begin
            rand_msg_d();
            e = expect_d();
            c0 = ccnt_d;
            run_d(1'b1);
            $display("keycache_off[%0d]: hash=%h comps=%0d", it, hash_d, ccnt_d - c0);
            checks++; if (hash_d !== e) $display("FAIL reuse_ignored_hash: got %h, required %h", hash_d, e); else passes++;
            checks++; if (ccnt_d - c0 !== COMP_D) $display("FAIL reuse_ignored_comps: got %0d, required %0d", ccnt_d - c0, COMP_D); else passes++;
        end
`endif
    endtask

    initial begin
        test_reset();
        test_rfc();
        test_block_boundary();
        test_random();
        test_start_ignored();
        test_reset_midop();
        test_keycache();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
